rst_sequencer: RTL
==================

// Module: rst_sequencer
// PURPOSE
//  Upstream neighbour of the sys_clk divider. Takes the raw board reset and a
//  clock-source lock flag. Produces staged, synchronously released resets:
//  - rst_core_n drives the divider and the core logic.
//  - rst_periph_n drives the MRAM and peripheral logic, released later.
//  All outputs assert asynchronously and release only on a sys_clk edge.
// PARAMETERS
//  SYNC_STAGES  2   flops per synchronizer chain (>=2)
//  HOLD_CYCLES  16  sys_clk cycles in S_HOLD before rst_core_n releases (>=1)
//  STAGE_GAP    8   cycles between rst_core_n and rst_periph_n release (>=1)
//  CNT_W        8   counter width; must hold max(HOLD_CYCLES,STAGE_GAP)-1
// PORTS
//  sys_clk       in   1  single clock for the whole block
//  rst_n         in   1  asynchronous active-low reset (raw, button/POR)
//  clk_locked    in   1  clock-source lock, asynchronous, active-high
//  soft_rst_req  in   1  soft re-sequence request, async level (RST_SEQ_SOFT_EN only)
//  rst_core_n    out  1  staged reset, core/divider domain, active-low
//  rst_periph_n  out  1  staged reset, peripheral domain, active-low
//  seq_done      out  1  high while in S_RUN
// BEHAVIOUR
//  - rst_n low (async): all flops clear. rst_core_n=0, rst_periph_n=0,
//    seq_done=0, state=S_RESET, cnt=0. Applies mid-sequence too.
//  - rst_sync_n: rst_n release through SYNC_STAGES flops; assert async, deassert sync.
//  - locked_s: clk_locked through SYNC_STAGES flops, cleared by rst_n.
//  - Edge numbering: edge 0 = first sys_clk rise with rst_n high.
//  - FSM (all outputs registered; cnt counts 0..N-1):
//    S_RESET     -> S_WAIT_LOCK when rst_sync_n=1.
//    S_WAIT_LOCK -> S_HOLD when locked_s=1; cnt<=0.
//    S_HOLD      cnt++; at cnt==HOLD_CYCLES-1 -> S_REL_CORE, rst_core_n<=1, cnt<=0.
//    S_REL_CORE  cnt++; at cnt==STAGE_GAP-1 -> S_RUN, rst_periph_n<=1, seq_done<=1.
//    S_RUN       hold.
//  - Lock already high at release: rst_core_n rises on edge
//    SYNC_STAGES+1+HOLD_CYCLES (19 with defaults). rst_periph_n rises
//    STAGE_GAP edges later (27).
//  - locked_s=0 in S_HOLD/S_REL_CORE/S_RUN:
//    next edge -> S_WAIT_LOCK, cnt<=0, both resets 0, seq_done 0.
//    Lock loss takes priority over counter terminal count on the same edge.
//  - Lock glitch shorter than one sys_clk may be missed. Intended.
//  - Release order always core before periph. Assertion is always simultaneous.
//  - Counter never wraps; it is cleared on every state entry.
// CONFIGURATION
//  RST_SEQ_SOFT_EN defined:
//   - soft_rst_req is synchronized and rising-edge detected.
//   - A rising edge in S_HOLD, S_REL_CORE or S_RUN: next edge -> S_HOLD,
//     cnt<=0, both resets 0, seq_done 0. Re-sequence follows without re-syncing rst_n.
//   - Ignored in S_RESET and S_WAIT_LOCK.
//   - Lock loss wins over a soft request on the same edge.
//   - A held-high level does not retrigger.
//  RST_SEQ_SOFT_EN undefined:
//   - soft_rst_req port and its logic are absent.
// STRUCTURE
//  - Package rst_seq_pkg: state enum (S_RESET, S_WAIT_LOCK, S_HOLD,
//    S_REL_CORE, S_RUN), state width localparam, default timing constants.
//  - Sub-module sync_bit (param STAGES, RST_VAL): N-flop synchronizer with
//    async active-low clear. Instantiated for rst release, clk_locked and soft_rst_req.
// TESTING
//  1 clk_locked=1, release rst_n -> rst_core_n rises edge 19, rst_periph_n
//    edge 27, seq_done with rst_periph_n.
//  2 clk_locked=0 at release, raise it 40 cycles later -> S_WAIT_LOCK holds.
//    rst_core_n rises HOLD_CYCLES+3 edges after the lock rise.
//  3 In S_RUN drop clk_locked -> both resets 0 and seq_done 0 within
//    SYNC_STAGES+1 edges. Re-raise it -> full hold/gap sequence repeats.
//  4 Assert rst_n low at edge 22 (between the two releases) -> outputs 0
//    immediately, with no clock edge. Sequence restarts from edge 0 on release.
//  5 (RST_SEQ_SOFT_EN) Pulse soft_rst_req 3 cycles in S_RUN -> one re-sequence:
//    rst_core_n low for HOLD_CYCLES+1 edges, rst_periph_n low STAGE_GAP longer.
//  6 Same-edge lock loss and HOLD terminal count -> S_WAIT_LOCK, rst_core_n stays 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - state type and default timing for the staged reset sequencer
package rst_seq_pkg;

  localparam int STATE_W         = 3;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_STAGE_GAP   = 8;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic [STATE_W-1:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_HOLD      = 3'd2,
    S_REL_CORE  = 3'd3,
    S_RUN       = 3'd4
  } state_t;

endpackage

// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - lock/soft-request inputs and staged reset outputs
// soft_rst_req exists only when RST_SEQ_SOFT_EN is defined.
interface rst_sequencer_if;

  logic clk_locked;
`ifdef RST_SEQ_SOFT_EN
  logic soft_rst_req;
`endif
  logic rst_core_n;
  logic rst_periph_n;
  logic seq_done;

  modport slave (
    input  clk_locked,
`ifdef RST_SEQ_SOFT_EN
    input  soft_rst_req,
`endif
    output rst_core_n,
    output rst_periph_n,
    output seq_done
  );

  modport master (
    output clk_locked,
`ifdef RST_SEQ_SOFT_EN
    output soft_rst_req,
`endif
    input  rst_core_n,
    input  rst_periph_n,
    input  seq_done
  );

endinterface

// File: rtl/rst_sequencer_sync_bit.sv
// rtl/rst_sequencer_sync_bit.sv - N-flop single-bit synchronizer with async active-low clear
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_ff;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ff <= {STAGES{RST_VAL}};
    end else begin
      r_ff <= {r_ff[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged core/peripheral reset release gated by clock lock
// RST_SEQ_SOFT_EN adds a synchronized soft re-sequence request.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP   = DEF_STAGE_GAP,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  rst_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_core_n, r_periph_n, r_done;
  logic             w_core_n_nxt, w_periph_n_nxt, w_done_nxt;
  logic             w_rst_sync_n, w_locked_s, w_soft_rise, w_active;

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rst_sync (
    .i_clk(sys_clk), .i_rst_n(rst_n), .i_d(1'b1), .o_q(w_rst_sync_n)
  );

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
    .i_clk(sys_clk), .i_rst_n(rst_n), .i_d(bus.clk_locked), .o_q(w_locked_s)
  );

`ifdef RST_SEQ_SOFT_EN
  logic w_soft_s;
  logic r_soft_d;

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_soft_sync (
    .i_clk(sys_clk), .i_rst_n(rst_n), .i_d(bus.soft_rst_req), .o_q(w_soft_s)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_soft_d <= 1'b0;
    end else begin
      r_soft_d <= w_soft_s;
    end
  end

  assign w_soft_rise = w_soft_s & ~r_soft_d;
`else
  assign w_soft_rise = 1'b0;
`endif

  assign w_active = (r_state == S_HOLD) || (r_state == S_REL_CORE) || (r_state == S_RUN);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RESET;
      r_cnt      <= '0;
      r_core_n   <= 1'b0;
      r_periph_n <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_core_n   <= w_core_n_nxt;
      r_periph_n <= w_periph_n_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_core_n_nxt   = r_core_n;
    w_periph_n_nxt = r_periph_n;
    w_done_nxt     = r_done;

    case (r_state)
      S_RESET: begin
        if (w_rst_sync_n) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      S_HOLD: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt  = S_REL_CORE;
          w_core_n_nxt = 1'b1;
          w_cnt_nxt    = '0;
        end
      end
      S_REL_CORE: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == GAP_LAST) begin
          w_state_nxt    = S_RUN;
          w_periph_n_nxt = 1'b1;
          w_done_nxt     = 1'b1;
          w_cnt_nxt      = '0;
        end
      end
      S_RUN: begin
      end
      default: begin
        w_state_nxt = S_RESET;
      end
    endcase

    // Lock loss overrides both terminal counts and a soft request on the same edge.
    if (w_active && !w_locked_s) begin
      w_state_nxt    = S_WAIT_LOCK;
      w_cnt_nxt      = '0;
      w_core_n_nxt   = 1'b0;
      w_periph_n_nxt = 1'b0;
      w_done_nxt     = 1'b0;
    end else if (w_active && w_soft_rise) begin
      w_state_nxt    = S_HOLD;
      w_cnt_nxt      = '0;
      w_core_n_nxt   = 1'b0;
      w_periph_n_nxt = 1'b0;
      w_done_nxt     = 1'b0;
    end
  end

  assign bus.rst_core_n   = r_core_n;
  assign bus.rst_periph_n = r_periph_n;
  assign bus.seq_done     = r_done;

endmodule
